keypad_emulator: RTL and testbench

Emulates the 4-row × 3-column telephone-style keypad matrix, acting as the switch side that the keypad scanner drives. The scanner drives one-hot `row` and reads `column`. This block takes queued key codes from a producer, "presses" each key for a programmed time, then releases it for a programmed gap. It drives `column` exactly as a physical switch closure would. It sits in the lab bench / self-test path, in place of the real keypad, so the scanner can be exercised without hands.

---
 rtl/keypad_if.sv | 13 +
 rtl/keypad_emulator.sv | 189 ++++++++++++++++++
 tb/tb_keypad_emulator.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// keypad_if: key-code handshake between a producer and the keypad emulator.
//   key_code  [3:0]  code of the key to press (0x0-0x9, 0xE, 0xF are valid)
//   key_valid        producer offers key_code
//   key_ready        emulator can accept; transfer when valid && ready
// Modports: master = producer side, slave = emulator side.
interface keypad_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: stands in for a 4-row x 3-column telephone keypad.
// Queued key codes are "pressed" for HOLD_CYCLES, then released for
// GAP_CYCLES. While a key is pressed, the column output reflects the switch
// closure for whatever rows the scanner is driving.
//   clk           sole clock, rising edge
//   rst_n         synchronous active-low reset
//   key           keypad_if.slave handshake (key_code/key_valid/key_ready)
//   row   [3:0]   scanner row drive (normally one-hot)
//   column[2:0]   emulated column return, registered
//   busy          press/gap in progress or FIFO non-empty
//   pressed_code  code currently pressed (meaningful while pressing)
//   err           one-cycle pulse after an invalid code (0xA-0xD) transfer
module keypad_emulator #(
    parameter int unsigned HOLD_CYCLES = 200000000,
    parameter int unsigned GAP_CYCLES  = 200000000
) (
    input  logic       clk,
    input  logic       rst_n,
    keypad_if.slave    key,
    input  logic [3:0] row,
    output logic [2:0] column,
    output logic       busy,
    output logic [3:0] pressed_code,
    output logic       err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input FIFO, 4 x 4 bits
    // ------------------------------------------------------------------
    logic [3:0] fifo_mem [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic       code_ok;
    logic       xfer;
    logic       push;
    logic       pop;

    assign code_ok       = (key.key_code <= 4'h9) || (key.key_code >= 4'hE);
    // Ready is forced low while reset is asserted, not just after the flush.
    assign key.key_ready = rst_n && (count_reg != 3'd4);
    assign xfer          = key.key_valid && key.key_ready;
    // Invalid codes complete the handshake but are dropped here.
    assign push          = xfer && code_ok;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= key.key_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Press / gap sequencer
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [31:0] counter_reg;
    logic [31:0] counter_next;
    logic [3:0]  code_reg;
    logic [3:0]  code_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            counter_reg <= 32'd0;
            code_reg    <= 4'd0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            code_reg    <= code_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        code_next    = code_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != 3'd0) begin
                    pop          = 1'b1;
                    code_next    = fifo_mem[rd_ptr_reg];
                    counter_next = HOLD_LOAD;
                    state_next   = PRESS;
                end
            end
            PRESS: begin
                if (counter_reg == 32'd0) begin
                    counter_next = GAP_LOAD;
                    state_next   = GAP;
                end else begin
                    counter_next = counter_reg - 32'd1;
                end
            end
            GAP: begin
                if (counter_reg == 32'd0) begin
                    state_next = IDLE;
                end else begin
                    counter_next = counter_reg - 32'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Switch matrix: row/column position of the pressed key
    // ------------------------------------------------------------------
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [2:0] column_next;
    logic [2:0] column_reg;
    logic       err_reg;

    always_comb begin
        key_row = 4'b0000;
        key_col = 3'b000;
        case (code_reg)
            4'h1: begin key_row = 4'b0010; key_col = 3'b001; end
            4'h2: begin key_row = 4'b0010; key_col = 3'b010; end
            4'h3: begin key_row = 4'b0010; key_col = 3'b100; end
            4'h4: begin key_row = 4'b0100; key_col = 3'b001; end
            4'h5: begin key_row = 4'b0100; key_col = 3'b010; end
            4'h6: begin key_row = 4'b0100; key_col = 3'b100; end
            4'h7: begin key_row = 4'b1000; key_col = 3'b001; end
            4'h8: begin key_row = 4'b1000; key_col = 3'b010; end
            4'h9: begin key_row = 4'b1000; key_col = 3'b100; end
            4'hE: begin key_row = 4'b0001; key_col = 3'b001; end
            4'h0: begin key_row = 4'b0001; key_col = 3'b010; end
            4'hF: begin key_row = 4'b0001; key_col = 3'b100; end
            default: begin key_row = 4'b0000; key_col = 3'b000; end
        endcase
    end

    // Any driven row containing the key's row closes the switch, so
    // multi-row drive behaves like a real matrix.
    always_comb begin
        column_next = 3'b000;
        if ((state_reg == PRESS) && ((row & key_row) != 4'b0000)) begin
            column_next = key_col;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            column_reg <= 3'b000;
            err_reg    <= 1'b0;
        end else begin
            column_reg <= column_next;
            err_reg    <= xfer && !code_ok;
        end
    end

    assign column       = column_reg;
    assign err          = err_reg;
    assign pressed_code = code_reg;
    assign busy         = (state_reg != IDLE) || (count_reg != 3'd0);
endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;
    localparam int HOLD = 8;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row = 4'b0000;
    logic [2:0] column;
    logic       busy;
    logic [3:0] pressed_code;
    logic       err;

    keypad_if kif();

    keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (kif.slave),
        .row          (row),
        .column       (column),
        .busy         (busy),
        .pressed_code (pressed_code),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue, the current press as a
    // start cycle + code; the timeline follows from HOLD/GAP arithmetic.
    int         cyc = 0;
    logic [3:0] mq [$];
    bit         act = 0;
    int         ps = 0;
    logic [3:0] pcode = 4'd0;
    logic [2:0] e_col = 3'b000;
    logic       e_err = 1'b0;
    logic [3:0] e_pc = 4'd0;
    bit         xfer_flag = 0;
    int         xfer_cyc = 0;
    int         press_cnt = 0;

    function automatic bit code_ok(input logic [3:0] c);
        return (c <= 4'd9) || (c >= 4'd14);
    endfunction

    function automatic logic [3:0] row_of(input logic [3:0] c);
        int k;
        k = int'(c) - 1;
        if (k >= 0 && k <= 8) return 4'(1 << (k / 3 + 1));
        if (c == 4'h0 || c >= 4'hE) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [2:0] col_of(input logic [3:0] c);
        int k;
        k = int'(c) - 1;
        if (k >= 0 && k <= 8) return 3'(1 << (k % 3));
        case (c)
            4'hE:    return 3'b001;
            4'h0:    return 3'b010;
            4'hF:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit fsm_active(input int c);
        return act && c >= ps && c <= ps + HOLD + GAP - 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // One clock: advance the model over the edge, then compare all outputs.
    task automatic step();
        bit in_press;
        bit pop;
        bit xf;
        @(posedge clk);
        xf = 0;
        if (!rst_n) begin
            mq.delete();
            act   = 0;
            e_col = 3'b000;
            e_err = 1'b0;
            e_pc  = 4'd0;
        end else begin
            in_press = act && cyc >= ps && cyc <= ps + HOLD - 1;
            xf       = kif.key_valid && (mq.size() < 4);
            pop      = !fsm_active(cyc) && (mq.size() > 0);
            e_err    = xf && !code_ok(kif.key_code);
            e_col    = (in_press && ((row & row_of(pcode)) != 4'b0000)) ? col_of(pcode) : 3'b000;
            if (xf) $display("xfer cyc=%0d code=%h", cyc, kif.key_code);
            if (pop) begin
                pcode = mq.pop_front();
                ps    = cyc + 1;
                act   = 1;
                e_pc  = pcode;
                press_cnt++;
            end
            if (xf && code_ok(kif.key_code)) mq.push_back(kif.key_code);
        end
        xfer_flag = xf;
        if (xf) xfer_cyc = cyc;
        cyc++;
        #1;
        chk("column", 32'(column), 32'(e_col));
        chk("err", 32'(err), 32'(e_err));
        chk("busy", 32'(busy), 32'(fsm_active(cyc) || mq.size() > 0));
        chk("key_ready", 32'(kif.key_ready), 32'(rst_n && mq.size() < 4));
        chk("pressed_code", 32'(pressed_code), 32'(e_pc));
    endtask

    task automatic send(input logic [3:0] c);
        int b;
        b = 0;
        kif.key_code  = c;
        kif.key_valid = 1'b1;
        do begin
            step();
            b++;
        end while (!xfer_flag && b < 60);
        kif.key_valid = 1'b0;
        chk("send_done", 32'(xfer_flag), 32'd1);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (busy && b < 200) begin
            step();
            b++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0] code;
        logic [3:0] row;
        logic [2:0] col;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int n;
        int b;
        int first_on;
        int run;
        int zeros;
        bit ended;
        logic [3:0] burst [6];
        int bidx;
        int nacc;
        int acc_cyc [$];
        int obs_start [$];
        logic [3:0] obs_code [$];
        logic [2:0] prev_col;
        bit saw_low;
        int rise_cyc;
        bit any_busy;
        bit any_col;

        vecs[0]  = '{4'h1, 4'b0010, 3'b001};
        vecs[1]  = '{4'h1, 4'b0100, 3'b000};
        vecs[2]  = '{4'h4, 4'b0100, 3'b001};
        vecs[3]  = '{4'h4, 4'b1000, 3'b000};
        vecs[4]  = '{4'h7, 4'b1000, 3'b001};
        vecs[5]  = '{4'h7, 4'b0001, 3'b000};
        vecs[6]  = '{4'hE, 4'b0001, 3'b001};
        vecs[7]  = '{4'hE, 4'b0010, 3'b000};
        vecs[8]  = '{4'h0, 4'b0001, 3'b010};
        vecs[9]  = '{4'h0, 4'b1000, 3'b000};
        vecs[10] = '{4'hF, 4'b0001, 3'b100};
        vecs[11] = '{4'hF, 4'b0100, 3'b000};
        vecs[12] = '{4'h8, 4'b1111, 3'b010};
        vecs[13] = '{4'h8, 4'b0000, 3'b000};
        vecs[14] = '{4'h3, 4'b0011, 3'b100};
        vecs[15] = '{4'h9, 4'b0111, 3'b000};

        kif.key_code  = 4'h0;
        kif.key_valid = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_key_ready", 32'(kif.key_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_column", 32'(column), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(kif.key_ready), 32'd1);

        // Single press of 5 on row 2
        row = 4'b0100;
        send(4'h5);
        n = xfer_cyc;
        first_on = -1; run = 0; zeros = 0; ended = 0;
        repeat (40) begin
            step();
            if (column == 3'b010 && !ended) begin
                if (first_on < 0) first_on = cyc;
                run++;
            end else if (first_on >= 0) begin
                ended = 1;
                if (column == 3'b000) zeros++;
            end
        end
        chk("t1_first_on", 32'(first_on), 32'(n + 3));
        chk("t1_run_len", 32'(run), 32'd8);
        chk("t1_zeros_ge5", 32'(zeros >= 5), 32'd1);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // Key map table
        for (int i = 0; i < 16; i++) begin
            n = press_cnt;
            send(vecs[i].code);
            b = 0;
            while (!(press_cnt > n && cyc >= ps) && b < 40) begin
                step();
                b++;
            end
            chk("tbl_press_seen", 32'(press_cnt > n), 32'd1);
            row = vecs[i].row;
            step();
            chk($sformatf("tbl_col_%0d", i), 32'(column), 32'(vecs[i].col));
            wait_idle();
        end

        // Burst of 6 with valid held high
        row = 4'b1111;
        burst[0] = 4'h1; burst[1] = 4'h2; burst[2] = 4'h3;
        burst[3] = 4'h4; burst[4] = 4'h5; burst[5] = 4'h6;
        bidx = 0; nacc = 0; saw_low = 0; rise_cyc = -1;
        prev_col = 3'b000;
        kif.key_code  = burst[0];
        kif.key_valid = 1'b1;
        b = 0;
        while (obs_start.size() < 6 && b < 300) begin
            step();
            b++;
            if (xfer_flag) begin
                acc_cyc.push_back(xfer_cyc);
                bidx++;
                if (bidx < 6) kif.key_code = burst[bidx];
                else kif.key_valid = 1'b0;
            end
            if (kif.key_valid && !kif.key_ready) saw_low = 1;
            if (saw_low && rise_cyc < 0 && kif.key_ready) rise_cyc = cyc;
            if (prev_col == 3'b000 && column != 3'b000) begin
                obs_start.push_back(cyc);
                obs_code.push_back(pressed_code);
            end
            prev_col = column;
        end
        kif.key_valid = 1'b0;
        chk("burst_starts", 32'(obs_start.size()), 32'd6);
        chk("burst_accepts", 32'(acc_cyc.size()), 32'd6);
        if (acc_cyc.size() >= 4)
            chk("burst_first4_b2b", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
        chk("burst_ready_low", 32'(saw_low), 32'd1);
        if (obs_start.size() >= 2)
            chk("burst_ready_rise", 32'(rise_cyc), 32'(obs_start[1] - 1));
        for (int i = 0; i < obs_start.size(); i++) begin
            chk("burst_order", 32'(obs_code[i]), 32'(burst[i]));
            if (i > 0)
                chk("burst_spacing", 32'(obs_start[i] - obs_start[i-1]), 32'(HOLD + GAP + 1));
        end
        wait_idle();

        // Invalid code
        send(4'hB);
        chk("inv_err_hi", 32'(err), 32'd1);
        step();
        chk("inv_err_lo", 32'(err), 32'd0);
        any_busy = 0; any_col = 0;
        repeat (20) begin
            step();
            if (busy) any_busy = 1;
            if (column != 3'b000) any_col = 1;
        end
        chk("inv_no_busy", 32'(any_busy), 32'd0);
        chk("inv_no_press", 32'(any_col), 32'd0);

        // Reset mid-press with two codes queued
        row = 4'b1000;
        send(4'h9);
        send(4'h1);
        send(4'h2);
        b = 0;
        while (column == 3'b000 && b < 30) begin
            step();
            b++;
        end
        chk("rst_mid_col_on", 32'(column), 32'b100);
        rst_n = 1'b0;
        step();
        chk("rst_mid_col_off", 32'(column), 32'd0);
        step();
        rst_n = 1'b1;
        any_busy = 0; any_col = 0;
        repeat (30) begin
            step();
            if (busy) any_busy = 1;
            if (column != 3'b000) any_col = 1;
        end
        chk("rst_mid_no_busy", 32'(any_busy), 32'd0);
        chk("rst_mid_no_press", 32'(any_col), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            kif.key_valid = 1'($urandom_range(0, 2) == 0);
            kif.key_code  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) row = 4'($urandom_range(0, 15));
            else row = 4'(1 << $urandom_range(0, 3));
            rst_n = ($urandom_range(0, 249) != 0);
            step();
        end
        kif.key_valid = 1'b0;
        rst_n = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
